// File: rtl/ofdm_rx_symbol_framer.sv
// ofdm_rx_symbol_framer
//   Frames the oversampled OFDM RX stream into FFT-sized symbols. On each
//   qualified sym_start the cyclic prefix is skipped, then the raw symbol is
//   decimated by OSR so that 2**FFT_EXP I/Q samples reach the FFT stage, the
//   first one flagged with fft_data_start.
//
//   Build option OFDM_FRAMER_AVG_EN:
//     undefined - pick-one decimation, the sample at dec_phase within each
//                 OSR group is forwarded (dec_phase latched once per symbol).
//     defined   - boxcar mean of each OSR group, rounded half up, emitted one
//                 cycle after the group's last sample; dec_phase is ignored.
//
//   All logic is on the rising edge of sys_clk; sys_rst and sys_init are
//   equivalent synchronous clears that override every other input.
module ofdm_rx_symbol_framer #(
  parameter int SAMPLE_BIT_WIDTH  = 12,
  parameter int SYMBOL_LENGTH     = 320,
  parameter int RAW_SYMBOL_LENGTH = 256,
  parameter int OSR               = 4,
  parameter int FFT_EXP           = 6
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        sys_init,
  input  logic                        sym_start,
  input  logic [SAMPLE_BIT_WIDTH-1:0] rx_data_i,
  input  logic [SAMPLE_BIT_WIDTH-1:0] rx_data_q,
  input  logic                        rx_data_valid,
  input  logic [$clog2(OSR)-1:0]      dec_phase,
  output logic [SAMPLE_BIT_WIDTH-1:0] fft_data_i,
  output logic [SAMPLE_BIT_WIDTH-1:0] fft_data_q,
  output logic                        fft_data_valid,
  output logic                        fft_data_start,
  output logic [15:0]                 sym_count,
  output logic                        resync_err
);

  // Derived geometry
  localparam int CP_LEN = SYMBOL_LENGTH - RAW_SYMBOL_LENGTH;
  localparam int PH_W   = $clog2(OSR);
  localparam int RAW_W  = $clog2(RAW_SYMBOL_LENGTH);
  localparam int CP_W   = $clog2(CP_LEN + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CP,
    ST_PAYLOAD
  } state_t;

  state_t            state_q, state_d;
  logic [CP_W-1:0]   cp_cnt_q, cp_cnt_d;
  logic [RAW_W-1:0]  raw_cnt_q, raw_cnt_d;
  logic [PH_W-1:0]   phase_q, phase_d;

  // Per-sample decode results
  logic              take;       // this valid sample is a payload sample
  logic [RAW_W-1:0]  take_idx;   // its raw index within the symbol
  logic [PH_W-1:0]   take_phase; // decimation phase in force for it
  logic              resync;
  logic              sym_done;

  // Output-side decode
  logic                        sel;
  logic                        sel_first;
  logic [SAMPLE_BIT_WIDTH-1:0] out_i;
  logic [SAMPLE_BIT_WIDTH-1:0] out_q;

  // Next-state and per-sample classification; gaps (valid=0) hold everything.
  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cp_cnt_d   = cp_cnt_q;
    raw_cnt_d  = raw_cnt_q;
    phase_d    = phase_q;
    take       = 1'b0;
    take_idx   = raw_cnt_q;
    take_phase = phase_q;
    resync     = 1'b0;
    sym_done   = 1'b0;

    if (rx_data_valid) begin
      if (sym_start) begin
        // A start strobe always begins a fresh symbol; only an interrupted
        // payload is an error, a restart inside the CP is silent.
        resync = (state_q == ST_PAYLOAD);
        if (CP_LEN == 0) begin
          // No prefix: the start sample is already raw sample 0.
          state_d    = ST_PAYLOAD;
          phase_d    = dec_phase;
          take       = 1'b1;
          take_idx   = '0;
          take_phase = dec_phase;
          raw_cnt_d  = RAW_W'(1);
        end else if (CP_LEN == 1) begin
          // The start sample is the whole prefix.
          state_d   = ST_PAYLOAD;
          phase_d   = dec_phase;
          raw_cnt_d = '0;
        end else begin
          state_d  = ST_CP;
          cp_cnt_d = CP_W'(1);
        end
      end else begin
        unique case (state_q)
          ST_CP: begin
            if (cp_cnt_q == CP_W'(CP_LEN - 1)) begin
              // Last CP sample: phase is frozen here for the whole symbol.
              state_d   = ST_PAYLOAD;
              raw_cnt_d = '0;
              phase_d   = dec_phase;
            end else begin
              cp_cnt_d = cp_cnt_q + CP_W'(1);
            end
          end
          ST_PAYLOAD: begin
            take = 1'b1;
            if (raw_cnt_q == RAW_W'(RAW_SYMBOL_LENGTH - 1)) begin
              // Symbol complete; a following sym_start is handled from IDLE,
              // so back-to-back symbols need no idle sample in between.
              state_d   = ST_IDLE;
              raw_cnt_d = '0;
              sym_done  = 1'b1;
            end else begin
              raw_cnt_d = raw_cnt_q + RAW_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Framing state register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || sys_init) begin
      state_q   <= ST_IDLE;
      cp_cnt_q  <= '0;
      raw_cnt_q <= '0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      cp_cnt_q  <= cp_cnt_d;
      raw_cnt_q <= raw_cnt_d;
      phase_q   <= phase_d;
    end
  end

`ifdef OFDM_FRAMER_AVG_EN
  localparam int ACC_W = SAMPLE_BIT_WIDTH + PH_W;

  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic signed [ACC_W-1:0] rnd_i, rnd_q;
  logic                    grp_first;
  logic                    grp_last;

  // Group running sum (restarted on the first sample of each OSR group) and
  // half-up rounded mean; the sum width cannot overflow for OSR samples.
  always_comb begin
    grp_first = (take_idx[PH_W-1:0] == '0);
    grp_last  = (take_idx[PH_W-1:0] == {PH_W{1'b1}});
    sum_i     = (grp_first ? '0 : acc_i_q) + ACC_W'(signed'(rx_data_i));
    sum_q     = (grp_first ? '0 : acc_q_q) + ACC_W'(signed'(rx_data_q));
    rnd_i     = sum_i + ACC_W'(OSR / 2);
    rnd_q     = sum_q + ACC_W'(OSR / 2);
    out_i     = SAMPLE_BIT_WIDTH'(rnd_i >>> PH_W);
    out_q     = SAMPLE_BIT_WIDTH'(rnd_q >>> PH_W);
    sel       = take && grp_last;
    sel_first = take_idx == RAW_W'(OSR - 1);
  end

  // Accumulator registers, updated on payload samples only
  always_ff @(posedge sys_clk) begin
    if (sys_rst || sys_init) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else if (take) begin
      acc_i_q <= sum_i;
      acc_q_q <= sum_q;
    end
  end
`else
  // Pick-one decimation: forward the sample at the latched phase.
  always_comb begin
    out_i     = rx_data_i;
    out_q     = rx_data_q;
    sel       = take && (take_idx[PH_W-1:0] == take_phase);
    sel_first = take_idx < RAW_W'(OSR);
  end
`endif

  // Registered outputs: one cycle of latency, data held between strobes
  always_ff @(posedge sys_clk) begin
    if (sys_rst || sys_init) begin
      fft_data_i     <= '0;
      fft_data_q     <= '0;
      fft_data_valid <= 1'b0;
      fft_data_start <= 1'b0;
      sym_count      <= '0;
      resync_err     <= 1'b0;
    end else begin
      fft_data_valid <= sel;
      fft_data_start <= sel && sel_first;
      resync_err     <= resync;
      if (sel) begin
        fft_data_i <= out_i;
        fft_data_q <= out_q;
      end
      if (sym_done) begin
        sym_count <= sym_count + 16'd1;
      end
    end
  end

endmodule
